fp_adder_arbiter: RTL and testbench

Shares one pipelined single-precision float adder IP among NUM_REQ requesters, such as the transformation, projection and scaling stages, so the design instantiates only one adder. The block round-robin arbitrates operand pairs into the adder and tags each issued operation with its requester id. It routes every adder result back to the requester that issued it. After reset it flushes operations still in flight in the unresettable adder pipeline before accepting new requests.

---
 rtl/fp_adder_arbiter_if.sv | 32 +++
 rtl/fp_adder_arbiter.sv | 147 ++++++++++++++
 tb/tb_fp_adder_arbiter.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_adder_arbiter_if.sv
// Requester, adder-IP and status signals of the shared float adder arbiter.
interface fp_adder_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0]         req_valid_in;
    logic [NUM_REQ-1:0][31:0]   req_a_in;
    logic [NUM_REQ-1:0][31:0]   req_b_in;
    logic [NUM_REQ-1:0]         req_ready_out;
    logic [NUM_REQ-1:0]         res_valid_out;
    logic [31:0]                res_data_out;
    logic [31:0]                add_a_out;
    logic [31:0]                add_b_out;
    logic                       add_valid_out;
    logic [31:0]                add_result_in;
    logic                       add_result_valid_in;
    logic                       busy_out;
    logic                       err_out;

    // Arbiter side
    modport slave (
        input  req_valid_in, req_a_in, req_b_in, add_result_in, add_result_valid_in,
        output req_ready_out, res_valid_out, res_data_out, add_a_out, add_b_out,
               add_valid_out, busy_out, err_out
    );

    // Requesters plus adder IP side
    modport master (
        output req_valid_in, req_a_in, req_b_in, add_result_in, add_result_valid_in,
        input  req_ready_out, res_valid_out, res_data_out, add_a_out, add_b_out,
               add_valid_out, busy_out, err_out
    );
endinterface

// File: rtl/fp_adder_arbiter.sv
// Round-robin sharing of one pipelined float adder among NUM_REQ requesters.
// Each issued operation's requester id rides a tag FIFO so the in-order
// adder result can be steered back; after reset the adder pipeline is
// drained (FLUSH) before any request is accepted.
module fp_adder_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned ADD_LATENCY = 11,
    parameter int unsigned TAG_DEPTH   = 16
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    fp_adder_arbiter_if.slave bus
);
    localparam int unsigned IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned PTR_W     = $clog2(TAG_DEPTH);
    localparam int unsigned CNT_W     = PTR_W + 1;
    localparam int unsigned FLUSH_END = ADD_LATENCY + 1;
    localparam int unsigned FCNT_W    = $clog2(FLUSH_END + 1);

    typedef enum logic {FLUSH = 1'b0, RUN = 1'b1} state_t;

    state_t             state;
    state_t             state_next;
    logic [FCNT_W-1:0]  flush_cnt;
    logic [FCNT_W-1:0]  flush_cnt_next;

    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   rr_next;
    logic [IDX_W-1:0]   scan;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_any;

    logic [IDX_W-1:0]   tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_next;
    logic               push;
    logic               pop;
    logic               spurious;

    // FSM state register
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state     <= FLUSH;
            flush_cnt <= '0;
        end else begin
            state     <= state_next;
            flush_cnt <= flush_cnt_next;
        end
    end

    // FSM next state: drain the adder for ADD_LATENCY+1 cycles, then run
    always_comb begin
        state_next     = state;
        flush_cnt_next = flush_cnt;
        case (state)
            FLUSH: begin
                if (flush_cnt == FCNT_W'(FLUSH_END)) begin
                    state_next = RUN;
                end else begin
                    flush_cnt_next = flush_cnt + FCNT_W'(1);
                end
            end
            RUN:     state_next = RUN;
            default: state_next = FLUSH;
        endcase
    end

    // Round-robin grant: first valid at or after rr_ptr, only with tag room
    always_comb begin
        bus.req_ready_out = '0;
        grant_any         = 1'b0;
        grant_idx         = '0;
        scan              = rr_ptr;
        if (state == RUN && count < CNT_W'(TAG_DEPTH)) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                if (!grant_any && bus.req_valid_in[scan]) begin
                    grant_any = 1'b1;
                    grant_idx = scan;
                end
                scan = (scan == IDX_W'(NUM_REQ - 1)) ? '0 : scan + IDX_W'(1);
            end
            if (grant_any) begin
                bus.req_ready_out[grant_idx] = 1'b1;
            end
        end
    end

    // Tag FIFO control; results in FLUSH belong to pre-reset traffic
    always_comb begin
        push       = grant_any;
        pop        = (state == RUN) && bus.add_result_valid_in && (count != '0);
        spurious   = (state == RUN) && bus.add_result_valid_in && (count == '0);
        rr_next    = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // Tag storage, no reset needed: only read below the valid count
    always_ff @(posedge clk_in) begin
        if (push) begin
            tag_mem[wr_ptr] <= grant_idx;
        end
    end

    // Issue path, result return, pointers and status
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            bus.add_a_out     <= '0;
            bus.add_b_out     <= '0;
            bus.add_valid_out <= 1'b0;
            bus.res_valid_out <= '0;
            bus.res_data_out  <= '0;
            bus.busy_out      <= 1'b1;
            bus.err_out       <= 1'b0;
            rr_ptr            <= '0;
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count             <= '0;
        end else begin
            bus.add_valid_out <= push;
            if (push) begin
                bus.add_a_out <= bus.req_a_in[grant_idx];
                bus.add_b_out <= bus.req_b_in[grant_idx];
                wr_ptr        <= wr_ptr + PTR_W'(1);
                rr_ptr        <= rr_next;
            end
            if (pop) begin
                bus.res_valid_out <= NUM_REQ'(1) << tag_mem[rd_ptr];
                bus.res_data_out  <= bus.add_result_in;
                rd_ptr            <= rd_ptr + PTR_W'(1);
            end else begin
                bus.res_valid_out <= '0;
            end
            if (spurious) begin
                bus.err_out <= 1'b1;
            end
            count        <= count_next;
            bus.busy_out <= (state_next == FLUSH) || (count_next != '0);
        end
    end
endmodule

// File: tb/tb_fp_adder_arbiter.sv
// Scoreboard bench for fp_adder_arbiter with a table-driven adder model.
module tb_fp_adder_arbiter;
    localparam int unsigned N = 4;
    localparam int unsigned L = 11;
    localparam int unsigned D = 16;

    typedef struct {
        int          id;
        logic [31:0] sum;
        int          due;
    } exp_t;

    logic clk_in   = 1'b0;
    logic rst_n_in = 1'b0;
    int   cyc      = 0;
    int   n_cmp    = 0;
    int   n_fail   = 0;

    exp_t        exp_q [$];
    exp_t        mon_e;
    logic [31:0] held_q [$];
    logic [3:0]  last_gnt;
    int          req_cnt [N] = '{default: 0};
    int          waits   [N] = '{default: 0};

    logic        hold_mode = 1'b0;
    logic        rel_v     = 1'b0;
    logic        inj_v     = 1'b0;
    logic [31:0] rel_d     = '0;
    logic [31:0] inj_d     = '0;
    logic [L-1:0] pipe_v   = '0;
    logic [31:0]  pipe_d [L];

    // Hand-computed IEEE-754 single-precision sums
    logic [31:0] vec_a [8] = '{32'h3f800000, 32'h3fc00000, 32'h3f000000, 32'hbf800000,
                               32'h41200000, 32'h42c80000, 32'h00000000, 32'h40000000};
    logic [31:0] vec_b [8] = '{32'h40000000, 32'h40200000, 32'h3e800000, 32'h40400000,
                               32'h40c00000, 32'hc2100000, 32'h40e00000, 32'h40000000};
    logic [31:0] vec_s [8] = '{32'h40400000, 32'h40800000, 32'h3f400000, 32'h40000000,
                               32'h41800000, 32'h42800000, 32'h40e00000, 32'h40800000};

    fp_adder_arbiter_if #(.NUM_REQ(N)) bus ();

    fp_adder_arbiter #(.NUM_REQ(N), .ADD_LATENCY(L), .TAG_DEPTH(D)) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .bus      (bus)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        r = 32'hdeadbeef;
        for (int i = 0; i < 8; i++) begin
            if (vec_a[i] == a && vec_b[i] == b) r = vec_s[i];
        end
        return r;
    endfunction

    function automatic int vidx(input int i);
        return (i + 6 + 3 * req_cnt[i]) % 8;
    endfunction

    // Unresettable adder pipeline; in hold mode finished results are parked
    always @(posedge clk_in) begin
        if (hold_mode && pipe_v[L-1] === 1'b1) held_q.push_back(pipe_d[L-1]);
        pipe_v    <= {pipe_v[L-2:0], bus.add_valid_out};
        pipe_d[0] <= fadd(bus.add_a_out, bus.add_b_out);
        for (int i = 1; i < L; i++) pipe_d[i] <= pipe_d[i-1];
    end

    assign bus.add_result_valid_in = inj_v | rel_v | (pipe_v[L-1] & ~hold_mode);
    assign bus.add_result_in       = inj_v ? inj_d : (rel_v ? rel_d : pipe_d[L-1]);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every result strobe must match the oldest outstanding issue
    always @(negedge clk_in) begin
        if (bus.res_valid_out !== '0 && bus.res_valid_out !== 'x) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_strobe: got %b, expected none (cycle %0d)",
                         bus.res_valid_out, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("res_strobe", 32'(bus.res_valid_out), 32'(1) << mon_e.id);
                check("res_data", bus.res_data_out, mon_e.sum);
                if (mon_e.due >= 0) check("res_latency", 32'(cyc), 32'(mon_e.due));
            end
        end
    end

    // One cycle of stimulus, called at a negedge; records any grant
    task automatic step(input logic [3:0] v);
        int g;
        bus.req_valid_in = v;
        for (int i = 0; i < N; i++) begin
            bus.req_a_in[i] = vec_a[vidx(i)];
            bus.req_b_in[i] = vec_b[vidx(i)];
        end
        #1;
        last_gnt = bus.req_ready_out;
        check("grant_legal", 32'($onehot0(last_gnt) && ((last_gnt & ~v) == 4'b0)), 32'd1);
        if (last_gnt != 4'b0) begin
            g = 0;
            for (int i = 0; i < N; i++) if (last_gnt[i]) g = i;
            exp_q.push_back('{id: g, sum: vec_s[vidx(g)], due: hold_mode ? -1 : cyc + int'(L) + 2});
            req_cnt[g]++;
        end
        @(negedge clk_in);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            step(4'b0);
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        step(4'b0);
        check("idle_busy", 32'(bus.busy_out), 32'd0);
    endtask

    initial begin
        int r;
        int last;
        int ngr;
        logic [3:0] pend;
        bus.req_valid_in = '0;
        bus.req_a_in     = '0;
        bus.req_b_in     = '0;
        repeat (3) @(negedge clk_in);

        // Reset values
        check("rst_ready", 32'(bus.req_ready_out), 32'd0);
        check("rst_res_valid", 32'(bus.res_valid_out), 32'd0);
        check("rst_res_data", bus.res_data_out, 32'd0);
        check("rst_add_a", bus.add_a_out, 32'd0);
        check("rst_add_b", bus.add_b_out, 32'd0);
        check("rst_add_valid", 32'(bus.add_valid_out), 32'd0);
        check("rst_busy", 32'(bus.busy_out), 32'd1);
        check("rst_err", 32'(bus.err_out), 32'd0);

        // Flush holds off requester 2, then it gets the first grant: 1.0 + 2.0
        rst_n_in = 1'b1;
        r = cyc;
        while (cyc < r + int'(L) + 2) begin
            step(4'b0100);
            check("flush_ready", 32'(last_gnt), 32'd0);
        end
        step(4'b0100);
        check("first_grant", 32'(last_gnt), 32'b0100);
        check("issue_valid", 32'(bus.add_valid_out), 32'd1);
        check("issue_a", bus.add_a_out, 32'h3f800000);
        check("issue_b", bus.add_b_out, 32'h40000000);
        step(4'b0);
        check("issue_valid_drop", 32'(bus.add_valid_out), 32'd0);
        wait_drain();

        // Round robin with all requesters valid: rr_ptr now 3
        last = 2;
        repeat (12) begin
            step(4'b1111);
            check("rr_order", 32'(last_gnt), 32'(1) << ((last + 1) % N));
            last = (last + 1) % N;
        end
        wait_drain();

        // Backpressure: withheld results fill the tag FIFO
        hold_mode = 1'b1;
        ngr = 0;
        for (int i = 0; i < int'(D) + 6; i++) begin
            step(4'b1111);
            check("bp_grant", 32'(last_gnt != 4'b0), 32'(i < int'(D)));
            if (last_gnt != 4'b0) ngr++;
        end
        check("bp_total", 32'(ngr), 32'(D));
        repeat (L) step(4'b1111);
        check("bp_held", 32'(held_q.size()), 32'(D));
        rel_v = 1'b1;
        rel_d = held_q.pop_front();
        step(4'b1111);
        check("bp_pop_no_grant", 32'(last_gnt), 32'd0);
        rel_v = 1'b0;
        step(4'b1111);
        check("bp_regrant", 32'(last_gnt != 4'b0), 32'd1);
        step(4'b1111);
        check("bp_full_again", 32'(last_gnt), 32'd0);
        repeat (L + 2) step(4'b0);
        while (held_q.size() != 0) begin
            rel_v = 1'b1;
            rel_d = held_q.pop_front();
            step(4'b0);
        end
        rel_v = 1'b0;
        hold_mode = 1'b0;
        wait_drain();

        // Spurious result with nothing outstanding
        check("spur_err_before", 32'(bus.err_out), 32'd0);
        inj_v = 1'b1;
        inj_d = 32'h12345678;
        step(4'b0);
        inj_v = 1'b0;
        check("spur_err", 32'(bus.err_out), 32'd1);
        repeat (4) begin
            step(4'b0);
            check("spur_err_sticky", 32'(bus.err_out), 32'd1);
        end

        // Reset with operations in flight: their results must vanish
        repeat (5) step(4'b1111);
        repeat (2) step(4'b0);
        rst_n_in = 1'b0;
        step(4'b0);
        exp_q.delete();
        rst_n_in = 1'b1;
        r = cyc;
        while (cyc < r + int'(L) + 2) begin
            step(4'b1111);
            check("reflush_ready", 32'(last_gnt), 32'd0);
            check("reflush_err", 32'(bus.err_out), 32'd0);
        end
        step(4'b1111);
        check("reflush_first_grant", 32'(last_gnt), 32'b0001);
        wait_drain();

        // Sparse mixed traffic; valids held until granted
        pend = '0;
        repeat (1000) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(2) == 0) pend[i] = 1'b1;
            end
            step(pend);
            for (int i = 0; i < N; i++) begin
                if (last_gnt[i]) begin
                    check("starve", 32'(waits[i] > int'(N) - 1), 32'd0);
                    waits[i] = 0;
                    pend[i]  = 1'b0;
                end else if (pend[i] && last_gnt != 4'b0) begin
                    waits[i]++;
                end
            end
        end
        wait_drain();
        check("final_err", 32'(bus.err_out), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
